// File: rtl/voice_scheduler_pkg.sv
// Shared widths, note payload and mixer state encoding for the voice scheduler.
package voice_scheduler_pkg;

    localparam int unsigned NUM_VOICES = 3;
    localparam int unsigned NOTE_W     = 6;
    localparam int unsigned DUR_W      = 6;
    localparam int unsigned SAMPLE_W   = 16;
    // Two guard bits so the sum of three full-scale samples cannot wrap
    localparam int unsigned SUM_W      = SAMPLE_W + 2;

    typedef enum logic [1:0] {
        MIX_IDLE    = 2'd0,
        MIX_COLLECT = 2'd1,
        MIX_EMIT    = 2'd2
    } mix_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } note_req_t;

endpackage

// File: rtl/chord_mixer.sv
// Gathers one sample from each voice that was busy at request time and emits
// their scaled sum as a single output sample.
module chord_mixer
    import voice_scheduler_pkg::*;
#(
    parameter int unsigned VOICES = NUM_VOICES
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         play,
    input  logic [VOICES-1:0]            voice_busy,
    input  logic [VOICES-1:0]            voice_done,
    input  logic [SAMPLE_W*VOICES-1:0]   voice_sample,
    input  logic [VOICES-1:0]            voice_sample_ready,
    input  logic                         generate_next_sample,
    output logic signed [SAMPLE_W-1:0]   sample_out,
    output logic                         new_sample_ready
);

    mix_state_t                  state, state_d;
    logic [VOICES-1:0]           mask, mask_d;
    logic [VOICES-1:0]           sticky, sticky_d;
    logic signed [SAMPLE_W-1:0]  cap   [VOICES];
    logic signed [SAMPLE_W-1:0]  cap_d [VOICES];
    logic signed [SAMPLE_W-1:0]  sample_d;
    logic                        pulse_d;
    logic signed [SUM_W-1:0]     sum;

    // Sum of captured samples for voices still in the chord
    always_comb begin
        sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (mask[i]) begin
                sum = sum + SUM_W'(cap[i]);
            end
        end
    end

    always_comb begin
        state_d  = state;
        mask_d   = mask;
        sticky_d = sticky;
        cap_d    = cap;
        sample_d = sample_out;
        pulse_d  = 1'b0;
        case (state)
            MIX_IDLE: begin
                if (generate_next_sample) begin
                    sticky_d = '0;
                    if (play && (voice_busy != '0)) begin
                        mask_d  = voice_busy;
                        state_d = MIX_COLLECT;
                    end else begin
                        mask_d  = '0;
                        state_d = MIX_EMIT;
                    end
                end
            end
            MIX_COLLECT: begin
                if (!play) begin
                    mask_d  = '0;
                    state_d = MIX_EMIT;
                end else begin
                    // First sample per voice wins; a finishing voice drops out
                    for (int i = 0; i < VOICES; i++) begin
                        if (mask[i] && voice_sample_ready[i] && !sticky[i]) begin
                            sticky_d[i] = 1'b1;
                            cap_d[i]    = voice_sample[SAMPLE_W*i +: SAMPLE_W];
                        end
                        if (voice_done[i]) begin
                            mask_d[i] = 1'b0;
                        end
                    end
                    if ((mask_d & ~sticky_d) == '0) begin
                        state_d = MIX_EMIT;
                    end
                end
            end
            MIX_EMIT: begin
                sample_d = SAMPLE_W'(sum >>> 2);
                pulse_d  = 1'b1;
                state_d  = MIX_IDLE;
            end
            default: state_d = MIX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= MIX_IDLE;
            mask             <= '0;
            sticky           <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                cap[i] <= '0;
            end
        end else begin
            state            <= state_d;
            mask             <= mask_d;
            sticky           <= sticky_d;
            sample_out       <= sample_d;
            new_sample_ready <= pulse_d;
            cap              <= cap_d;
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Hands incoming notes to the lowest free note_player voice, tracks voice
// occupancy and mixes the active voices into one output sample stream.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int unsigned NUM_VOICES = voice_scheduler_pkg::NUM_VOICES
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           play,
    input  logic                           note_valid,
    input  logic [NOTE_W-1:0]              note_in,
    input  logic [DUR_W-1:0]               duration_in,
    output logic                           note_ready,
    output logic [NUM_VOICES-1:0]          voice_load,
    output logic [NOTE_W-1:0]              voice_note,
    output logic [DUR_W-1:0]               voice_duration,
    input  logic [NUM_VOICES-1:0]          voice_done,
    output logic [NUM_VOICES-1:0]          voice_busy,
    input  logic [SAMPLE_W*NUM_VOICES-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_sample_ready,
    input  logic                           generate_next_sample,
    output logic signed [SAMPLE_W-1:0]     sample_out,
    output logic                           new_sample_ready
);

    note_req_t               payload;
    logic                    accept;
    logic [NUM_VOICES-1:0]   free_pick;

    assign note_ready = play && (voice_busy != {NUM_VOICES{1'b1}});
    assign accept     = note_valid && note_ready;
    // Isolates the lowest clear bit of the occupancy vector
    assign free_pick  = ~voice_busy & (voice_busy + NUM_VOICES'(1));

    assign voice_note     = payload.note;
    assign voice_duration = payload.duration;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            voice_busy <= '0;
            voice_load <= '0;
            payload    <= '0;
        end else begin
            voice_load <= '0;
            if (accept) begin
                voice_load <= free_pick;
                payload    <= '{note: note_in, duration: duration_in};
            end
            // Occupancy is frozen while paused, including done reports
            if (play) begin
                voice_busy <= (voice_busy & ~voice_done) | ({NUM_VOICES{accept}} & free_pick);
            end
        end
    end

    chord_mixer #(
        .VOICES (NUM_VOICES)
    ) u_mixer (
        .clk                  (clk),
        .reset_n              (reset_n),
        .play                 (play),
        .voice_busy           (voice_busy),
        .voice_done           (voice_done),
        .voice_sample         (voice_sample),
        .voice_sample_ready   (voice_sample_ready),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready)
    );

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_voice_scheduler;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               play;
    logic               note_valid;
    logic [5:0]         note_in;
    logic [5:0]         duration_in;
    logic               note_ready;
    logic [2:0]         voice_load;
    logic [5:0]         voice_note;
    logic [5:0]         voice_duration;
    logic [2:0]         voice_done;
    logic [2:0]         voice_busy;
    logic [47:0]        voice_sample;
    logic [2:0]         voice_sample_ready;
    logic               generate_next_sample;
    logic signed [15:0] sample_out;
    logic               new_sample_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    voice_scheduler dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .play                 (play),
        .note_valid           (note_valid),
        .note_in              (note_in),
        .duration_in          (duration_in),
        .note_ready           (note_ready),
        .voice_load           (voice_load),
        .voice_note           (voice_note),
        .voice_duration       (voice_duration),
        .voice_done           (voice_done),
        .voice_busy           (voice_busy),
        .voice_sample         (voice_sample),
        .voice_sample_ready   (voice_sample_ready),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy set, and a chord round as a wanted/received set
    bit [2:0] m_busy;
    int       m_load;
    int       m_note;
    int       m_dur;
    bit       in_round;
    bit       emit_next;
    bit [2:0] want;
    bit [2:0] have;
    int       got [3];
    int       pend_value;
    int       m_sample;
    bit       m_pulse;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = '0; m_load = 0; m_note = 0; m_dur = 0;
            in_round = 0; emit_next = 0; want = '0; have = '0;
            pend_value = 0; m_sample = 0; m_pulse = 0;
        end else begin
            bit [2:0] old_busy;
            int       free_idx;
            int       s;
            old_busy = m_busy;
            m_pulse  = 0;
            if (emit_next) begin
                m_sample  = pend_value;
                m_pulse   = 1;
                emit_next = 0;
            end else if (in_round) begin
                if (!play) begin
                    in_round = 0; emit_next = 1; pend_value = 0;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (want[i]) begin
                            if (voice_done[i]) want[i] = 0;
                            else if (voice_sample_ready[i] && !have[i]) begin
                                have[i] = 1;
                                got[i]  = int'($signed(voice_sample[16*i +: 16]));
                            end
                        end
                    end
                    if ((want & ~have) == 3'b000) begin
                        s = 0;
                        for (int i = 0; i < 3; i++) if (want[i]) s += got[i];
                        in_round = 0; emit_next = 1; pend_value = s >>> 2;
                    end
                end
            end else if (generate_next_sample) begin
                if (play && old_busy != 3'b000) begin
                    in_round = 1; want = old_busy; have = '0;
                end else begin
                    emit_next = 1; pend_value = 0;
                end
            end
            m_load = 0;
            if (play) begin
                free_idx = -1;
                for (int i = 2; i >= 0; i--) if (!old_busy[i]) free_idx = i;
                if (note_valid && free_idx >= 0) begin
                    m_load = 1 << free_idx;
                    m_busy[free_idx] = 1;
                    m_note = int'(note_in);
                    m_dur  = int'(duration_in);
                end
                for (int i = 0; i < 3; i++) if (voice_done[i] && old_busy[i]) m_busy[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("note_ready", int'(note_ready), int'(play && (m_busy != 3'b111)));
        check("voice_load", int'(voice_load), m_load);
        check("voice_busy", int'(voice_busy), int'(m_busy));
        check("voice_note", int'(voice_note), m_note);
        check("voice_duration", int'(voice_duration), m_dur);
        check("sample_out", int'(sample_out), m_sample);
        check("new_sample_ready", int'(new_sample_ready), int'(m_pulse));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; play = 1'b0; note_valid = 1'b0; note_in = '0; duration_in = '0;
        voice_done = '0; voice_sample = '0; voice_sample_ready = '0; generate_next_sample = 1'b0;
        repeat (3) step();
        check("lit_rst_busy", int'(voice_busy), 0);
        check("lit_rst_sample", int'(sample_out), 0);
        check("lit_rst_pulse", int'(new_sample_ready), 0);
        reset_n = 1'b1; play = 1'b1;
        step();

        // Nothing busy: zero sample two cycles after the request
        generate_next_sample = 1'b1;
        step();
        generate_next_sample = 1'b0;
        check("lit_empty_pulse_early", int'(new_sample_ready), 0);
        step();
        check("lit_empty_pulse", int'(new_sample_ready), 1);
        check("lit_empty_sample", int'(sample_out), 0);
        step();

        // First note lands on voice 0
        note_valid = 1'b1; note_in = 6'd20; duration_in = 6'd10;
        #1;
        check("lit_ready_free", int'(note_ready), 1);
        step();
        note_valid = 1'b0;
        check("lit_load_v0", int'(voice_load), 1);
        check("lit_note_20", int'(voice_note), 20);
        check("lit_dur_10", int'(voice_duration), 10);
        check("lit_busy_001", int'(voice_busy), 1);
        step();
        check("lit_load_clear", int'(voice_load), 0);

        // Fill all voices, fourth note waits for voice 1 to finish
        voice_done = 3'b001;
        step();
        voice_done = 3'b000;
        check("lit_busy_freed", int'(voice_busy), 0);
        note_valid = 1'b1; note_in = 6'd1;
        step();
        check("lit_b2b_load0", int'(voice_load), 1);
        note_in = 6'd2;
        step();
        check("lit_b2b_load1", int'(voice_load), 2);
        note_in = 6'd3;
        step();
        check("lit_b2b_load2", int'(voice_load), 4);
        note_in = 6'd4;
        #1;
        check("lit_full_not_ready", int'(note_ready), 0);
        step();
        step();
        check("lit_full_no_load", int'(voice_load), 0);
        voice_done = 3'b010;
        step();
        voice_done = 3'b000;
        check("lit_v1_freed_ready", int'(note_ready), 1);
        step();
        note_valid = 1'b0;
        check("lit_fourth_to_v1", int'(voice_load), 2);
        check("lit_fourth_note", int'(voice_note), 4);

        // Two-voice chord: (4000 - 1000) / 4
        voice_done = 3'b100;
        step();
        voice_done = 3'b000;
        check("lit_busy_011", int'(voice_busy), 3);
        generate_next_sample = 1'b1;
        voice_sample = {16'h0000, 16'hFC18, 16'h0FA0};
        step();
        generate_next_sample = 1'b0;
        voice_sample_ready = 3'b001;
        step();
        voice_sample_ready = 3'b000;
        step();
        voice_sample_ready = 3'b010;
        step();
        voice_sample_ready = 3'b000;
        check("lit_chord_no_early_pulse", int'(new_sample_ready), 0);
        step();
        check("lit_chord_pulse", int'(new_sample_ready), 1);
        check("lit_chord_750", int'(sample_out), 750);
        step();
        check("lit_chord_pulse_once", int'(new_sample_ready), 0);
        check("lit_chord_hold", int'(sample_out), 750);

        // Three full-scale voices must not overflow
        note_valid = 1'b1; note_in = 6'd5;
        step();
        note_valid = 1'b0;
        check("lit_busy_111", int'(voice_busy), 7);
        generate_next_sample = 1'b1;
        step();
        generate_next_sample = 1'b0;
        voice_sample = {3{16'h7FFF}};
        voice_sample_ready = 3'b111;
        step();
        voice_sample_ready = 3'b000;
        step();
        check("lit_max_pulse", int'(new_sample_ready), 1);
        check("lit_max_24575", int'(sample_out), 24575);
        step();

        // Reset in the middle of collecting
        generate_next_sample = 1'b1;
        step();
        generate_next_sample = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("lit_mid_rst_sample", int'(sample_out), 0);
        check("lit_mid_rst_pulse", int'(new_sample_ready), 0);
        check("lit_mid_rst_busy", int'(voice_busy), 0);
        check("lit_mid_rst_note", int'(voice_note), 0);
        step();
        step();
        reset_n = 1'b1;
        voice_sample_ready = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            check("lit_no_stale_pulse", int'(new_sample_ready), 0);
        end
        voice_sample_ready = 3'b000;

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            play        = ($urandom_range(0, 15) != 0);
            note_valid  = ($urandom_range(0, 1) == 1);
            note_in     = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom());
            duration_in = 6'($urandom());
            for (int i = 0; i < 3; i++) begin
                voice_done[i]         = ($urandom_range(0, 9) == 0);
                voice_sample_ready[i] = ($urandom_range(0, 2) == 0);
            end
            case ($urandom_range(0, 7))
                0:       voice_sample = {3{16'h8000}};
                1:       voice_sample = {3{16'h7FFF}};
                default: voice_sample = 48'({$urandom(), $urandom()});
            endcase
            generate_next_sample = ($urandom_range(0, 5) == 0);
            step();
        end
        reset_n = 1'b1; note_valid = 1'b0; generate_next_sample = 1'b0;
        voice_done = '0; voice_sample_ready = '0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of note_player voices served (fixed 3 for this revision).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port play  input  1  high = scheduling and mixing enabled.
REQ-005 SHALL have ports note_valid  input  1, note_in  input  6, duration_in  input  6: note offer from song reader.
REQ-006 SHALL have port note_ready  output  1  note accepted when note_valid && note_ready at a clock edge.
REQ-007 SHALL have ports voice_load  output  3 (one-hot pulse), voice_note  output  6, voice_duration  output  6: drive note_player load_new_note/note_to_load/duration_to_load.
REQ-008 SHALL have port voice_done  input  3  per-voice done_with_note.
REQ-009 SHALL have port voice_busy  output  3  per-voice occupancy.
REQ-010 SHALL have ports voice_sample  input  48 (voice i at bits 16i+15:16i, signed), voice_sample_ready  input  3.
REQ-011 SHALL have ports generate_next_sample  input  1, sample_out  output  16 signed, new_sample_ready  output  1 (one-cycle pulse).

Function
REQ-012 SHALL assert note_ready combinationally iff play is high and at least one voice_busy bit is 0.
REQ-013 SHALL, on accept, assign the lowest-index free voice, pulse its voice_load bit for exactly one cycle starting the next cycle, with voice_note/voice_duration registered from note_in/duration_in.
REQ-014 SHALL set voice_busy[i] on the cycle voice_load[i] pulses and clear it the cycle after voice_done[i] is seen high; voice_done on a non-busy voice SHALL be ignored.
REQ-015 SHALL treat note_in = 0 (rest) as an ordinary note: a voice is loaded and held busy for its duration.
REQ-016 SHALL hold voice_load at 0 and keep voice_busy unchanged while play is low.
REQ-017 SHALL implement mixer FSM IDLE -> COLLECT -> EMIT -> IDLE.
REQ-018 SHALL, in IDLE on generate_next_sample, latch mask = voice_busy and clear sticky-ready bits; go to COLLECT if mask nonzero and play high, else to EMIT with sum 0.
REQ-019 SHALL, in COLLECT, set sticky bit i on voice_sample_ready[i] && mask[i] and capture voice_sample slice i that cycle.
REQ-020 SHALL clear mask[i] in COLLECT when voice_done[i] is seen, removing that voice from the sum.
REQ-021 SHALL leave COLLECT for EMIT the cycle after all masked voices are sticky (or mask becomes empty).
REQ-022 SHALL abort COLLECT to EMIT with sum 0 if play falls.
REQ-023 SHALL in EMIT register sample_out = (sign-extended 18-bit sum of captured masked samples) arithmetic-shifted right by 2, truncated to 16 bits, and pulse new_sample_ready one cycle.
REQ-024 SHALL ignore generate_next_sample outside IDLE.
REQ-025 SHALL hold sample_out between EMIT states.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear voice_busy, voice_load, voice_note, voice_duration, mask, sticky bits, sample_out, new_sample_ready and force IDLE, including mid-COLLECT.
REQ-027 SHALL resume normal operation on the first clock edge after reset_n rises.

Structure
REQ-028 SHALL place NUM_VOICES, NOTE_W=6, DUR_W=6, SAMPLE_W=16 and the mixer state encoding in the shared package.
REQ-029 SHALL implement the mixer (REQ-017..025) as sub-module chord_mixer; allocation stays in the top level.

Verification
REQ-030 SHALL cover: all voices free, offer note 20 dur 10 -> voice_load=001 next cycle, voice_note=20, voice_busy=001.
REQ-031 SHALL cover: three back-to-back notes then a fourth -> loads 001,010,100; note_ready low until voice_done[1] pulses, fourth note goes to voice 1.
REQ-032 SHALL cover: busy=011, samples 4000 and -1000, readies 2 cycles apart -> one new_sample_ready pulse, sample_out=750.
REQ-033 SHALL cover: busy=000, generate_next_sample -> sample_out=0, new_sample_ready 2 cycles later.
REQ-034 SHALL cover: three voices at 32767 -> sample_out=24575 (no overflow).
REQ-035 SHALL cover: reset_n low mid-COLLECT -> outputs 0 immediately, IDLE, no stale pulse after release.
